// File: rtl/tape_player.sv
`default_nettype none
// ============================================================================
// Module      : tape_player
// Description : Plays a byte image from memory as a biphase-mark cassette
//               signal (leader, sync byte, data), timed by the motor relay.
// Revision    : 1.0 - initial release
// ============================================================================
module tape_player #(
    parameter int         HALF_CYCLES = 8571,
    parameter int         LEADER_LEN  = 256,
    parameter logic [7:0] SYNC_BYTE   = 8'h16
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] base_addr,
    input  logic [15:0] length,
    input  logic        motor,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        cass_out,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam int                c_PH_W    = (2 * HALF_CYCLES > 1) ? $clog2(2 * HALF_CYCLES) : 1;
    localparam logic [c_PH_W-1:0] c_PH_HALF = c_PH_W'(HALF_CYCLES);
    localparam logic [c_PH_W-1:0] c_PH_LAST = c_PH_W'(2 * HALF_CYCLES - 1);
    localparam logic [15:0]       c_LEADER  = 16'(LEADER_LEN);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LEADER = 2'd1,
        S_SYNC   = 2'd2,
        S_DATA   = 2'd3
    } state_t;

    state_t            r_state,      w_state_nx;
    logic [c_PH_W-1:0] r_phase,      w_phase_nx;
    logic [2:0]        r_bit_idx,    w_bit_nx;
    logic [7:0]        r_shift,      w_shift_nx;
    logic [15:0]       r_byte_cnt,   w_byte_cnt_nx;
    logic [15:0]       r_len,        w_len_nx;
    logic              r_cass,       w_cass_nx;
    logic              r_done,       w_done_nx;
    logic              r_underrun,   w_underrun_nx;
    logic [7:0]        r_hold,       w_hold_nx;
    logic              r_hold_valid, w_hold_valid_nx;
    logic              r_mem_rd,     w_mem_rd_nx;
    logic [15:0]       r_fetch_addr, w_fetch_addr_nx;
    logic [15:0]       r_fetch_left, w_fetch_left_nx;
    logic              w_boundary;
    logic              w_advance;
    logic              w_load;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_phase      <= '0;
            r_bit_idx    <= 3'd0;
            r_shift      <= 8'd0;
            r_byte_cnt   <= 16'd0;
            r_len        <= 16'd0;
            r_cass       <= 1'b0;
            r_done       <= 1'b0;
            r_underrun   <= 1'b0;
            r_hold       <= 8'd0;
            r_hold_valid <= 1'b0;
            r_mem_rd     <= 1'b0;
            r_fetch_addr <= 16'd0;
            r_fetch_left <= 16'd0;
        end else begin
            r_state      <= w_state_nx;
            r_phase      <= w_phase_nx;
            r_bit_idx    <= w_bit_nx;
            r_shift      <= w_shift_nx;
            r_byte_cnt   <= w_byte_cnt_nx;
            r_len        <= w_len_nx;
            r_cass       <= w_cass_nx;
            r_done       <= w_done_nx;
            r_underrun   <= w_underrun_nx;
            r_hold       <= w_hold_nx;
            r_hold_valid <= w_hold_valid_nx;
            r_mem_rd     <= w_mem_rd_nx;
            r_fetch_addr <= w_fetch_addr_nx;
            r_fetch_left <= w_fetch_left_nx;
        end
    end

    always_comb begin
        w_state_nx      = r_state;
        w_phase_nx      = r_phase;
        w_bit_nx        = r_bit_idx;
        w_shift_nx      = r_shift;
        w_byte_cnt_nx   = r_byte_cnt;
        w_len_nx        = r_len;
        w_cass_nx       = r_cass;
        w_done_nx       = 1'b0;
        w_underrun_nx   = r_underrun;
        w_hold_nx       = r_hold;
        w_hold_valid_nx = r_hold_valid;
        w_mem_rd_nx     = r_mem_rd;
        w_fetch_addr_nx = r_fetch_addr;
        w_fetch_left_nx = r_fetch_left;
        w_boundary      = (r_phase == '0) && (r_bit_idx == 3'd0);
        w_advance       = 1'b0;
        w_load          = 1'b0;

        if (r_state == S_IDLE) begin
            if (start && !stop) begin
                w_state_nx      = S_LEADER;
                w_phase_nx      = '0;
                w_bit_nx        = 3'd0;
                w_byte_cnt_nx   = 16'd0;
                w_len_nx        = length;
                w_underrun_nx   = 1'b0;
                w_fetch_addr_nx = base_addr;
                w_fetch_left_nx = length;
                w_hold_valid_nx = 1'b0;
            end
        end else if (stop) begin
            w_state_nx      = S_IDLE;
            w_mem_rd_nx     = 1'b0;
            w_hold_valid_nx = 1'b0;
        end else begin
            if (motor) begin
                if (!w_boundary) begin
                    w_advance = 1'b1;
                end else begin
                    // Byte boundary: choose the byte for the cell starting now.
                    // r_state names the section of the byte being sent.
                    case (r_state)
                        S_LEADER: begin
                            w_advance = 1'b1;
                            if (r_byte_cnt != c_LEADER) begin
                                w_shift_nx    = 8'd0;
                                w_byte_cnt_nx = r_byte_cnt + 16'd1;
                            end else begin
                                w_state_nx    = S_SYNC;
                                w_shift_nx    = SYNC_BYTE;
                                w_byte_cnt_nx = 16'd0;
                            end
                        end
                        default: begin
                            if (r_byte_cnt == r_len) begin
                                w_state_nx = S_IDLE;
                                w_done_nx  = 1'b1;
                            end else if (r_hold_valid) begin
                                w_state_nx    = S_DATA;
                                w_shift_nx    = r_hold;
                                w_byte_cnt_nx = r_byte_cnt + 16'd1;
                                w_load        = 1'b1;
                                w_advance     = 1'b1;
                            end else begin
                                w_underrun_nx = 1'b1;
                            end
                        end
                    endcase
                end
            end

            if (w_advance) begin
                if ((r_phase == '0) || ((r_phase == c_PH_HALF) && r_shift[0])) begin
                    w_cass_nx = ~r_cass;
                end
                if (r_phase == c_PH_LAST) begin
                    w_phase_nx = '0;
                    w_shift_nx = r_shift >> 1;
                    w_bit_nx   = r_bit_idx + 3'd1;
                end else begin
                    w_phase_nx = r_phase + 1'b1;
                end
            end

            // Prefetch runs regardless of the motor so data is ready on resume
            if (w_load) begin
                w_hold_valid_nx = 1'b0;
            end
            if (r_mem_rd && mem_ack) begin
                w_hold_nx       = mem_data;
                w_hold_valid_nx = 1'b1;
                w_mem_rd_nx     = 1'b0;
                w_fetch_addr_nx = r_fetch_addr + 16'd1;
                w_fetch_left_nx = r_fetch_left - 16'd1;
            end else if (!r_mem_rd && !r_hold_valid && (r_fetch_left != 16'd0)) begin
                w_mem_rd_nx = 1'b1;
            end
            if (w_state_nx == S_IDLE) begin
                w_mem_rd_nx = 1'b0;
            end
        end
    end

    assign mem_addr = r_fetch_addr;
    assign mem_rd   = r_mem_rd;
    assign cass_out = r_cass;
    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_tape_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_tape_player
// Description : Directed self-checking bench for tape_player with a
//               biphase-mark decoder and a latency-configurable memory model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_player;

    localparam int HALF = 4;

    logic        clk_sys   = 1'b0;
    logic        reset_n   = 1'b0;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic        motor     = 1'b1;
    logic [15:0] base_addr = 16'd0;
    logic [15:0] length    = 16'd0;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack   = 1'b0;
    logic [7:0]  mem_data  = 8'd0;
    logic        cass_out;
    logic        busy;
    logic        done;
    logic        underrun;

    tape_player #(
        .HALF_CYCLES (HALF),
        .LEADER_LEN  (2),
        .SYNC_BYTE   (8'h16)
    ) dut (
        .clk_sys   (clk_sys),
        .reset_n   (reset_n),
        .start     (start),
        .stop      (stop),
        .base_addr (base_addr),
        .length    (length),
        .motor     (motor),
        .mem_addr  (mem_addr),
        .mem_rd    (mem_rd),
        .mem_ack   (mem_ack),
        .mem_data  (mem_data),
        .cass_out  (cass_out),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun)
    );

    always #5 clk_sys = ~clk_sys;

    // Memory: ack one cycle after rd, or 200 cycles later for slow_addr
    logic [7:0]  mem [0:65535];
    logic [15:0] addr_log [0:63];
    int          log_n = 0;
    int          wcnt  = 0;
    logic        slow_en   = 1'b0;
    logic [15:0] slow_addr = 16'd0;

    always @(posedge clk_sys) begin
        if (mem_ack) begin
            mem_ack <= 1'b0;
        end else if (mem_rd) begin
            if (wcnt >= ((slow_en && (mem_addr == slow_addr)) ? 200 : 0)) begin
                mem_ack  <= 1'b1;
                mem_data <= mem[mem_addr];
                wcnt     <= 0;
                if (log_n < 64) begin
                    addr_log[log_n] <= mem_addr;
                    log_n           <= log_n + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
            end
        end
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    int   act, toggles, rd_cycles, done_seen;
    logic last_cass;
    bit   have_start, got_mid;
    int   start_t;
    bit   bits [$];
    int   tog_hist [0:2047];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transitions are timed in motor-active cycles; one HALF after a cell start is a '1'
    task automatic decode(input int t);
        if (!have_start) begin
            have_start = 1'b1;
            start_t    = t;
            got_mid    = 1'b0;
        end else if (!got_mid && (t - start_t == HALF)) begin
            got_mid = 1'b1;
        end else begin
            bits.push_back(got_mid);
            start_t = t;
            got_mid = 1'b0;
        end
    endtask

    task automatic flush();
        if (have_start) bits.push_back(got_mid);
        have_start = 1'b0;
    endtask

    task automatic mon_reset();
        bits.delete();
        have_start = 1'b0;
        got_mid    = 1'b0;
        toggles    = 0;
        act        = 0;
        last_cass  = cass_out;
    endtask

    task automatic tick();
        logic m;
        m = motor;
        @(posedge clk_sys);
        @(negedge clk_sys);
        if (m) act++;
        if (cass_out !== last_cass) begin
            toggles++;
            decode(act);
            last_cass = cass_out;
        end
        if (mem_rd === 1'b1) rd_cycles++;
        if (done === 1'b1) done_seen++;
    endtask

    task automatic start_play(input logic [15:0] b, input logic [15:0] l);
        base_addr = b;
        length    = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        tog_hist[0] = toggles;
    endtask

    task automatic run_to_done(input int first, input int max, output int at, output logic b);
        at = -1;
        b  = 1'bx;
        for (int n = first; n <= max; n++) begin
            tick();
            tog_hist[n] = toggles;
            if (done === 1'b1) begin
                at = n;
                b  = busy;
                break;
            end
        end
    endtask

    task automatic check_stream(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                                input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                                input int nb);
        logic [7:0] exp [5];
        logic [7:0] got;
        exp[0] = b0; exp[1] = b1; exp[2] = b2; exp[3] = b3; exp[4] = b4;
        check({tag, "_bitcount"}, bits.size(), nb * 8);
        for (int i = 0; i < nb; i++) begin
            got = 8'd0;
            for (int j = 0; j < 8; j++) begin
                if (i * 8 + j < bits.size()) got[j] = bits[i * 8 + j];
            end
            check($sformatf("%s_byte%0d", tag, i), got, exp[i]);
        end
    endtask

    initial begin
        int   at, lg, rd0, ds;
        logic b, level, flat, lvl70;

        rd_cycles = 0;
        done_seen = 0;
        mem[16'h1000] = 8'hA5;
        mem[16'h1001] = 8'h01;
        mem[16'hFFFF] = 8'h3C;
        mem[16'h0000] = 8'hC3;

        repeat (3) tick();
        check("rst_cass", cass_out, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_mem_rd", mem_rd, 1'b0);
        check("rst_mem_addr", mem_addr, 16'h0000);
        reset_n = 1'b1;
        tick();

        // Basic play: 5 bytes x 64 cycles, done one cycle after the last cell ends
        mon_reset();
        lg = log_n;
        start_play(16'h1000, 16'd2);
        check("basic_busy_after_start", busy, 1'b1);
        run_to_done(1, 2000, at, b);
        flush();
        check("basic_done_cycle", at, 321);
        check("basic_busy_at_done", b, 1'b0);
        check("basic_leader_toggles", tog_hist[128], 16);
        check("basic_total_toggles", toggles, 40 + 8);
        check("basic_underrun", underrun, 1'b0);
        check("basic_addr0", addr_log[lg], 16'h1000);
        check("basic_addr1", addr_log[lg + 1], 16'h1001);
        check_stream("basic", 8'h00, 8'h00, 8'h16, 8'hA5, 8'h01, 5);
        tick();
        check("basic_done_one_cycle", done, 1'b0);

        // length = 0: leader + sync only, no reads
        mon_reset();
        rd0 = rd_cycles;
        start_play(16'h2000, 16'd0);
        run_to_done(1, 2000, at, b);
        flush();
        check("len0_done_cycle", at, 3 * 64 + 1);
        check("len0_no_reads", rd_cycles - rd0, 0);
        check("len0_underrun", underrun, 1'b0);
        check_stream("len0", 8'h00, 8'h00, 8'h16, 8'h00, 8'h00, 3);

        // Motor off for 100 cycles in the middle of SYNC
        mon_reset();
        start_play(16'h1000, 16'd2);
        repeat (150) tick();
        level = cass_out;
        flat  = 1'b1;
        motor = 1'b0;
        repeat (100) begin
            tick();
            if (cass_out !== level) flat = 1'b0;
        end
        motor = 1'b1;
        check("motor_flat", flat, 1'b1);
        check("motor_busy_held", busy, 1'b1);
        run_to_done(251, 2000, at, b);
        flush();
        check("motor_done_cycle", at, 321 + 100);
        check_stream("motor", 8'h00, 8'h00, 8'h16, 8'hA5, 8'h01, 5);

        // Slow memory on the second data byte: 140-cycle stall at the 0xA5/0x01 boundary
        slow_addr = 16'h1001;
        slow_en   = 1'b1;
        mon_reset();
        start_play(16'h1000, 16'd2);
        run_to_done(1, 2000, at, b);
        flush();
        slow_en = 1'b0;
        check("slow_done_cycle", at, 461);
        check("slow_underrun", underrun, 1'b1);
        check("slow_line_flat", tog_hist[396] - tog_hist[256], 0);
        check("slow_resume_toggle", tog_hist[397] - tog_hist[396], 1);
        check_stream("slow", 8'h00, 8'h00, 8'h16, 8'hA5, 8'h01, 5);

        // Stop at cycle 70
        mon_reset();
        start_play(16'h1000, 16'd2);
        repeat (70) tick();
        check("stop_busy_before", busy, 1'b1);
        lvl70 = cass_out;
        stop  = 1'b1;
        tick();
        stop  = 1'b0;
        check("stop_busy_after", busy, 1'b0);
        check("stop_mem_rd", mem_rd, 1'b0);
        check("stop_cass_hold", cass_out, lvl70);
        ds   = done_seen;
        flat = 1'b1;
        repeat (200) begin
            tick();
            if (cass_out !== lvl70) flat = 1'b0;
        end
        check("stop_no_done", done_seen - ds, 0);
        check("stop_cass_frozen", flat, 1'b1);
        check("stop_still_idle", busy, 1'b0);

        // start together with stop in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        check("startstop_busy", busy, 1'b0);
        tick();
        check("startstop_busy_later", busy, 1'b0);
        check("startstop_no_rd", mem_rd, 1'b0);

        // start while busy is ignored
        mon_reset();
        start_play(16'h1000, 16'd2);
        repeat (99) tick();
        base_addr = 16'hFFFF;
        length    = 16'd5;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        run_to_done(101, 2000, at, b);
        flush();
        check("rebusy_done_cycle", at, 321);
        check_stream("rebusy", 8'h00, 8'h00, 8'h16, 8'hA5, 8'h01, 5);

        // Address wrap
        mon_reset();
        lg = log_n;
        start_play(16'hFFFF, 16'd2);
        run_to_done(1, 2000, at, b);
        flush();
        check("wrap_done_cycle", at, 321);
        check("wrap_addr0", addr_log[lg], 16'hFFFF);
        check("wrap_addr1", addr_log[lg + 1], 16'h0000);
        check_stream("wrap", 8'h00, 8'h00, 8'h16, 8'h3C, 8'hC3, 5);

        // Asynchronous reset in the middle of DATA
        mon_reset();
        start_play(16'h1000, 16'd2);
        repeat (250) tick();
        for (int i = 0; i < 16 && cass_out !== 1'b1; i++) tick();
        check("rstmid_pre_cass", cass_out, 1'b1);
        check("rstmid_pre_busy", busy, 1'b1);
        reset_n = 1'b0;
        #1;
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_cass", cass_out, 1'b0);
        check("rstmid_mem_rd", mem_rd, 1'b0);
        check("rstmid_mem_addr", mem_addr, 16'h0000);
        tick();
        reset_n = 1'b1;
        tick();
        check("rstmid_stays_idle", busy, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
